// File: rtl/kernel_ctrl_chain.sv
// Host-facing kernel control FSM (ap_ctrl_hs / ap_ctrl_chain) that fans a start
// out to NUM_CH channels, collects their completions, and times the run.
module kernel_ctrl_chain #(
   parameter int NUM_CH         = 3,
   parameter int CNT_WIDTH      = 32,
   parameter int MODE           = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 ap_clk,
   input  logic                 areset,
   input  logic                 ap_start,
   input  logic                 ap_continue,
   output logic                 ap_idle,
   output logic                 ap_ready,
   output logic                 ap_done,
   input  logic [NUM_CH-1:0]    ch_enable,
   output logic [NUM_CH-1:0]    ch_start,
   input  logic [NUM_CH-1:0]    ch_done,
   output logic [NUM_CH-1:0]    ch_done_status,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] TO_LIMIT =
      CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic HS_MODE = (MODE == 0);

   state_t                state_q, state_d;
   logic                  ap_idle_q, ap_idle_d;
   logic                  ap_ready_q, ap_ready_d;
   logic                  ap_done_q, ap_done_d;
   logic [NUM_CH-1:0]     ch_start_q, ch_start_d;
   logic [NUM_CH-1:0]     status_q, status_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  timeout_q, timeout_d;
   logic                  all_done_s;
   logic                  timeout_hit_s;
   logic [CNT_WIDTH-1:0]  count_inc_s;

   // Next-state and next-output computation for the control FSM.
   always_comb begin
      state_d    = state_q;
      ap_idle_d  = ap_idle_q;
      ap_ready_d = 1'b0;
      ap_done_d  = ap_done_q;
      ch_start_d = {NUM_CH{1'b0}};
      status_d   = status_q;
      count_d    = count_q;
      timeout_d  = timeout_q;

      // Disabled channels are preloaded to 1, so their ch_done cannot matter.
      all_done_s    = &(status_q | ch_done);
      timeout_hit_s = TO_EN && (count_q == TO_LIMIT);
      count_inc_s   = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);

      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               state_d    = ST_RUN;
               ap_ready_d = 1'b1;
               ap_idle_d  = 1'b0;
               ch_start_d = ch_enable;
               status_d   = ~ch_enable;
               count_d    = {CNT_WIDTH{1'b0}};
               timeout_d  = 1'b0;
            end else begin
               ap_idle_d  = 1'b1;
            end
         end
         ST_RUN: begin
            status_d = status_q | ch_done;
            count_d  = count_inc_s;
            if (all_done_s) begin
               state_d   = ST_DONE;
               ap_done_d = 1'b1;
            end else if (timeout_hit_s) begin
               state_d   = ST_DONE;
               ap_done_d = 1'b1;
               timeout_d = 1'b1;
            end else begin
               state_d   = ST_RUN;
            end
         end
         ST_DONE: begin
            if (HS_MODE || ap_continue) begin
               state_d   = ST_IDLE;
               ap_done_d = 1'b0;
               ap_idle_d = 1'b1;
            end else begin
               state_d   = ST_DONE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            ap_done_d = 1'b0;
            ap_idle_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         ap_idle_q  <= 1'b1;
         ap_ready_q <= 1'b0;
         ap_done_q  <= 1'b0;
         ch_start_q <= {NUM_CH{1'b0}};
         status_q   <= {NUM_CH{1'b0}};
         count_q    <= {CNT_WIDTH{1'b0}};
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ap_idle_q  <= ap_idle_d;
         ap_ready_q <= ap_ready_d;
         ap_done_q  <= ap_done_d;
         ch_start_q <= ch_start_d;
         status_q   <= status_d;
         count_q    <= count_d;
         timeout_q  <= timeout_d;
      end
   end

   assign ap_idle        = ap_idle_q;
   assign ap_ready       = ap_ready_q;
   assign ap_done        = ap_done_q;
   assign ch_start       = ch_start_q;
   assign ch_done_status = status_q;
   assign cycle_count    = count_q;
   assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_kernel_ctrl_chain.sv
// Bench for kernel_ctrl_chain: an ap_ctrl_hs instance with a 16-cycle watchdog
// and an ap_ctrl_chain instance without one, driven from a shared clock/reset.
module tb_kernel_ctrl_chain;

   logic        ap_clk = 1'b0;
   logic        areset = 1'b1;

   // ap_ctrl_hs instance (MODE 0, TIMEOUT 16)
   logic        h_start = 1'b0, h_cont = 1'b0;
   logic        h_idle, h_ready, h_done_o, h_to;
   logic [2:0]  h_en = 3'b000, h_chs, h_chd = 3'b000, h_stat;
   logic [31:0] h_cnt;

   // ap_ctrl_chain instance (MODE 1, no watchdog)
   logic        c_start = 1'b0, c_cont = 1'b0;
   logic        c_idle, c_ready, c_done_o, c_to;
   logic [2:0]  c_en = 3'b000, c_chs, c_chd = 3'b000, c_stat;
   logic [31:0] c_cnt;

   int checks = 0;
   int errors = 0;
   int c_ready_cnt = 0;

   typedef struct {
      logic [2:0]  en;
      int          d0, d1, d2;   // RUN edge index of each ch_done pulse, -1 = never
      logic [31:0] exp_cnt;
      logic [2:0]  exp_stat;
      logic        exp_to;
   } vec_t;

   typedef struct {
      logic [31:0] cnt;
      logic [2:0]  stat;
      logic        to;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   kernel_ctrl_chain #(.NUM_CH(3), .CNT_WIDTH(32), .MODE(0), .TIMEOUT_CYCLES(16)) dut_hs (
      .ap_clk(ap_clk), .areset(areset), .ap_start(h_start), .ap_continue(h_cont),
      .ap_idle(h_idle), .ap_ready(h_ready), .ap_done(h_done_o),
      .ch_enable(h_en), .ch_start(h_chs), .ch_done(h_chd),
      .ch_done_status(h_stat), .cycle_count(h_cnt), .timeout_err(h_to));

   kernel_ctrl_chain #(.NUM_CH(3), .CNT_WIDTH(32), .MODE(1), .TIMEOUT_CYCLES(0)) dut_ch (
      .ap_clk(ap_clk), .areset(areset), .ap_start(c_start), .ap_continue(c_cont),
      .ap_idle(c_idle), .ap_ready(c_ready), .ap_done(c_done_o),
      .ch_enable(c_en), .ch_start(c_chs), .ch_done(c_chd),
      .ch_done_status(c_stat), .cycle_count(c_cnt), .timeout_err(c_to));

   always #5 ap_clk = ~ap_clk;

   always @(negedge ap_clk) begin
      if (c_ready === 1'b1) c_ready_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at a negedge; starts a run on dut_hs and scores it.
   task automatic run_hs(input vec_t v);
      exp_t e;
      bit   seen = 1'b0;
      h_en    = v.en;
      h_start = 1'b1;
      sb.push_back('{v.exp_cnt, v.exp_stat, v.exp_to});
      @(negedge ap_clk);
      h_start = 1'b0;
      chk("accept_ready", {31'd0, h_ready}, 32'd1);
      chk("accept_chstart", {29'd0, h_chs}, {29'd0, v.en});
      chk("accept_idle", {31'd0, h_idle}, 32'd0);
      chk("accept_cnt", h_cnt, 32'd0);
      for (int k = 1; k <= 40 && !seen; k++) begin
         h_chd = {v.d2 == k, v.d1 == k, v.d0 == k};
         @(negedge ap_clk);
         h_chd = 3'b000;
         if (k == 1) begin
            chk("ready_pulse", {31'd0, h_ready}, 32'd0);
            chk("chstart_pulse", {29'd0, h_chs}, 32'd0);
         end
         if (h_done_o === 1'b1) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_edge", k, e.cnt);
               chk("run_cnt", h_cnt, e.cnt);
               chk("run_stat", {29'd0, h_stat}, {29'd0, e.stat});
               chk("run_to", {31'd0, h_to}, {31'd0, e.to});
            end
         end
      end
      if (!seen) begin
         chk("done_wait", 32'd0, 32'd1);
         if (sb.size() != 0) e = sb.pop_front();
      end
      // channel completions in DONE/IDLE must not touch the latched flags
      h_chd = 3'b111;
      @(negedge ap_clk);
      chk("post_done", {31'd0, h_done_o}, 32'd0);
      chk("post_idle", {31'd0, h_idle}, 32'd1);
      @(negedge ap_clk);
      h_chd = 3'b000;
      chk("hold_stat", {29'd0, h_stat}, {29'd0, v.exp_stat});
      chk("hold_cnt", h_cnt, v.exp_cnt);
      chk("hold_to", {31'd0, h_to}, {31'd0, v.exp_to});
   endtask

   initial begin
      exp_t e;
      bit   seen;
      bit   any_done;

      vecs[0] = '{3'b111,  5, 10,  7, 32'd10, 3'b111, 1'b0};  // basic three-channel run
      vecs[1] = '{3'b111,  3,  4, -1, 32'd16, 3'b011, 1'b1};  // watchdog expiry
      vecs[2] = '{3'b010,  2,  6, -1, 32'd6,  3'b111, 1'b0};  // single channel, ch0 noise
      vecs[3] = '{3'b000, -1, -1, -1, 32'd1,  3'b111, 1'b0};  // nothing enabled
      vecs[4] = '{3'b111,  1,  2, 16, 32'd16, 3'b111, 1'b0};  // completion beats watchdog
      vecs[5] = '{3'b101,  1, -1,  1, 32'd1,  3'b111, 1'b0};  // done in the ch_start cycle

      repeat (3) @(negedge ap_clk);
      chk("rst_idle", {31'd0, h_idle}, 32'd1);
      chk("rst_ready", {31'd0, h_ready}, 32'd0);
      chk("rst_done", {31'd0, h_done_o}, 32'd0);
      chk("rst_chstart", {29'd0, h_chs}, 32'd0);
      chk("rst_stat", {29'd0, h_stat}, 32'd0);
      chk("rst_cnt", h_cnt, 32'd0);
      chk("rst_to", {31'd0, h_to}, 32'd0);
      chk("rst_c_idle", {31'd0, c_idle}, 32'd1);
      chk("rst_c_done", {31'd0, c_done_o}, 32'd0);

      // start on the first edge after reset release
      areset = 1'b0;
      for (int i = 0; i < 6; i++) run_hs(vecs[i]);

      // reset in the middle of a run
      h_en = 3'b111;
      h_start = 1'b1;
      @(negedge ap_clk);
      h_start = 1'b0;
      repeat (4) @(negedge ap_clk);
      chk("mid_cnt", h_cnt, 32'd4);
      areset = 1'b1;
      h_chd  = 3'b111;
      @(negedge ap_clk);
      chk("abort_idle", {31'd0, h_idle}, 32'd1);
      chk("abort_done", {31'd0, h_done_o}, 32'd0);
      chk("abort_stat", {29'd0, h_stat}, 32'd0);
      chk("abort_cnt", h_cnt, 32'd0);
      chk("abort_to", {31'd0, h_to}, 32'd0);
      chk("abort_ready", {31'd0, h_ready}, 32'd0);
      chk("abort_chstart", {29'd0, h_chs}, 32'd0);
      h_chd = 3'b101;
      @(negedge ap_clk);
      areset = 1'b0;
      any_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge ap_clk);
         if (h_done_o === 1'b1) any_done = 1'b1;
      end
      h_chd = 3'b000;
      chk("abort_no_done", {31'd0, any_done}, 32'd0);
      chk("abort_stat_idle", {29'd0, h_stat}, 32'd0);
      run_hs(vecs[0]);

      // ap_ctrl_chain: ap_done held until ap_continue
      c_ready_cnt = 0;
      c_en    = 3'b111;
      c_start = 1'b1;
      sb.push_back('{32'd10, 3'b111, 1'b0});
      @(negedge ap_clk);
      c_start = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         c_chd  = {k == 7, k == 10, k == 5};
         c_cont = (k == 3);
         @(negedge ap_clk);
         c_chd  = 3'b000;
         c_cont = 1'b0;
         if (c_done_o === 1'b1) begin
            seen = 1'b1;
            e = sb.pop_front();
            chk("c_done_edge", k, e.cnt);
            chk("c_cnt", c_cnt, e.cnt);
            chk("c_stat", {29'd0, c_stat}, {29'd0, e.stat});
            chk("c_to", {31'd0, c_to}, {31'd0, e.to});
         end
      end
      if (!seen) chk("c_done_wait", 32'd0, 32'd1);
      c_start = 1'b1;  // must be ignored while in DONE
      for (int j = 2; j <= 20; j++) begin
         @(negedge ap_clk);
         chk("c_done_held", {31'd0, c_done_o}, 32'd1);
         chk("c_idle_held", {31'd0, c_idle}, 32'd0);
      end
      c_start = 1'b0;
      c_cont  = 1'b1;
      @(negedge ap_clk);
      c_cont = 1'b0;
      chk("c_release_done", {31'd0, c_done_o}, 32'd0);
      chk("c_release_idle", {31'd0, c_idle}, 32'd1);
      repeat (2) @(negedge ap_clk);
      chk("c_ready_once", c_ready_cnt, 32'd1);
      chk("c_cnt_hold", c_cnt, 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
